// File: rtl/ulpb_node_tx_if.sv
// Host and ring-segment signals of a ULPB member-node transmitter.
// The master side is the node's host plus the surrounding ring; the slave side is the transmitter.
interface ulpb_node_tx_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  CLK_IN;
  logic                  DIN;
  logic                  DOUT;
  logic                  TX_REQ;
  logic [ADDR_WIDTH-1:0] TX_ADDR;
  logic [DATA_WIDTH-1:0] TX_DATA;
  logic                  TX_BUSY;
  logic                  TX_DONE;
  logic                  TX_FAIL;
  logic [1:0]            FAIL_CODE;

  modport master (
    output CLK_IN, DIN, TX_REQ, TX_ADDR, TX_DATA,
    input  DOUT, TX_BUSY, TX_DONE, TX_FAIL, FAIL_CODE
  );

  modport slave (
    input  CLK_IN, DIN, TX_REQ, TX_ADDR, TX_DATA,
    output DOUT, TX_BUSY, TX_DONE, TX_FAIL, FAIL_CODE
  );
endinterface

// File: rtl/ulpb_node_tx.sv
// ULPB member-node transmitter: requests the ring, arbitrates, shifts out an
// address/data payload with loop-back checking, sends end-of-message and checks
// the receiver ACK. While not driving, DOUT is a raw copy of DIN.
module ulpb_node_tx #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int IDLE_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic           CLK,
  input logic           RESET,
  ulpb_node_tx_if.slave bus
);
  localparam int PAY_W  = ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W  = (PAY_W > 4) ? $clog2(PAY_W) : 2;
  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  // End-of-message symbol, sent left to right
  localparam logic [3:0] EOM_PAT = 4'b0110;

  typedef enum logic [2:0] {
    ST_IDLE, ST_REQ, ST_ARB, ST_TURN, ST_SHIFT, ST_EOM, ST_ACK, ST_DRAIN
  } state_t;

  // Pin synchronisers and edge strobes
  logic clk_meta_q, clk_s_q, clk_prev_q;
  logic din_meta_q, din_s_q;
  logic rise_q, fall_q;

  // Bus idle detection and stall watchdog
  logic [IDLE_W-1:0] idle_cnt_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              bus_idle;
  logic              active;
  logic              timeout_hit;

  // Transmit FSM state
  state_t             state_q, state_d;
  logic               drive_en_q, drive_en_d;
  logic               drive_bit_q, drive_bit_d;
  logic [PAY_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         ack_q, ack_d;
  logic               req_armed_q, req_armed_d;
  logic               done_q, done_d;
  logic               fail_q, fail_d;
  logic [1:0]         code_q, code_d;
  logic               abort;
  logic [1:0]         abort_code;
  logic               loop_err;

  assign bus_idle    = (idle_cnt_q >= IDLE_W'(IDLE_CYCLES));
  assign active      = (state_q != ST_IDLE) && (state_q != ST_DRAIN);
  assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES));
  assign loop_err    = (din_s_q != drive_bit_q);

  // Synchronise the bus pins and turn bus-clock transitions into one-cycle strobes
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      clk_meta_q <= 1'b1;
      clk_s_q    <= 1'b1;
      clk_prev_q <= 1'b1;
      din_meta_q <= 1'b1;
      din_s_q    <= 1'b1;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      clk_meta_q <= bus.CLK_IN;
      clk_s_q    <= clk_meta_q;
      clk_prev_q <= clk_s_q;
      din_meta_q <= bus.DIN;
      din_s_q    <= din_meta_q;
      rise_q     <= clk_s_q & ~clk_prev_q;
      fall_q     <= ~clk_s_q & clk_prev_q;
    end
  end

  // Count consecutive cycles with bus clock and data both high, saturating at the idle threshold
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      idle_cnt_q <= '0;
    end else if (clk_s_q && din_s_q) begin
      if (!bus_idle) idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
    end else begin
      idle_cnt_q <= '0;
    end
  end

  // Stall watchdog: restarts on every bus-clock edge, only runs while a transaction owns the bus
  always_ff @(posedge CLK) begin
    if (!RESET || rise_q || fall_q || !active) begin
      to_cnt_q <= '0;
    end else if (!timeout_hit) begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  // FSM state and datapath registers
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      drive_en_q  <= 1'b0;
      drive_bit_q <= 1'b1;
      shreg_q     <= '0;
      cnt_q       <= '0;
      ack_q       <= '0;
      req_armed_q <= 1'b1;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      code_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      drive_en_q  <= drive_en_d;
      drive_bit_q <= drive_bit_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      req_armed_q <= req_armed_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      code_q      <= code_d;
    end
  end

  // Next-state logic: each bus-clock fall launches a bit, each rise checks or samples one
  always_comb begin
    state_d     = state_q;
    drive_en_d  = drive_en_q;
    drive_bit_d = drive_bit_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    ack_d       = ack_q;
    req_armed_d = req_armed_q;
    done_d      = 1'b0;
    fail_d      = 1'b0;
    code_d      = code_q;
    abort       = 1'b0;
    abort_code  = 2'd0;

    // A level request only counts again once it has been seen low
    if (!bus.TX_REQ) req_armed_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        drive_en_d = 1'b0;
        if (bus_idle && bus.TX_REQ && req_armed_q) begin
          shreg_d     = {bus.TX_ADDR, bus.TX_DATA};
          req_armed_d = 1'b0;
          drive_en_d  = 1'b1;
          drive_bit_d = 1'b0;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (fall_q) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (rise_q) begin
          cnt_d = '0;
          if (!din_s_q) begin
            abort      = 1'b1;
            abort_code = 2'd0;
          end else begin
            state_d = ST_TURN;
          end
        end
      end
      ST_TURN: begin
        // cnt_q[0] marks that the turnaround fall has happened; the next rise is ignored
        if (fall_q && !cnt_q[0]) begin
          drive_bit_d = 1'b1;
          cnt_d       = CNT_W'(1);
        end else if (rise_q && cnt_q[0]) begin
          cnt_d   = CNT_W'(PAY_W - 1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (fall_q) begin
          drive_bit_d = shreg_q[PAY_W-1];
          shreg_d     = {shreg_q[PAY_W-2:0], 1'b0};
        end else if (rise_q) begin
          // Mismatch wins over the move to EOM on the last bit
          if (loop_err) begin
            abort      = 1'b1;
            abort_code = 2'd2;
          end else if (cnt_q == '0) begin
            state_d = ST_EOM;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_EOM: begin
        if (fall_q) begin
          drive_bit_d = EOM_PAT[2'd3 - cnt_q[1:0]];
        end else if (rise_q) begin
          if (loop_err) begin
            abort      = 1'b1;
            abort_code = 2'd2;
          end else if (cnt_q[1:0] == 2'd3) begin
            drive_en_d = 1'b0;
            cnt_d      = '0;
            state_d    = ST_ACK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_ACK: begin
        if (rise_q) begin
          ack_d = {ack_q[0], din_s_q};
          if (cnt_q[1:0] == 2'd2) begin
            if ({ack_q, din_s_q} == 3'b011) begin
              done_d  = 1'b1;
              state_d = ST_DRAIN;
            end else begin
              abort      = 1'b1;
              abort_code = 2'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        drive_en_d = 1'b0;
        if (bus_idle) state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_DRAIN;
        drive_en_d = 1'b0;
      end
    endcase

    // A stalled bus clock aborts unless an edge already decided this cycle
    if (active && timeout_hit && !abort) begin
      abort      = 1'b1;
      abort_code = 2'd3;
    end

    if (abort) begin
      drive_en_d = 1'b0;
      fail_d     = 1'b1;
      done_d     = 1'b0;
      code_d     = abort_code;
      state_d    = ST_DRAIN;
    end
  end

  assign bus.DOUT      = drive_en_q ? drive_bit_q : bus.DIN;
  assign bus.TX_BUSY   = (state_q != ST_IDLE);
  assign bus.TX_DONE   = done_q;
  assign bus.TX_FAIL   = fail_q;
  assign bus.FAIL_CODE = code_q;

endmodule
